// File: rtl/aes128_pkg.sv
// aes128_pkg: shared constants and types for the AES-128 encryption slice.
package aes128_pkg;
  localparam int NR_AES128 = 10;
  localparam int BLK_W = 128;
  localparam int RK_IDX_W = 4;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} round_ctrl_state_t;
  typedef logic [127:0] aes_block_t;
endpackage

// File: rtl/aes128_encr_round_ctrl_ark.sv
// add_round_key_encr: initial AddRoundKey, XOR of a block with a round key.
module add_round_key_encr
  import aes128_pkg::*;
(
  input  aes_block_t data_i,
  input  aes_block_t rk_i,
  output aes_block_t data_o
);
  assign data_o = data_i ^ rk_i;
endmodule

// File: rtl/aes128_encr_round_ctrl.sv
// aes128_encr_round_ctrl: iterative AES-128 encryption sequencer, one round per clock.
// Optional abort input enabled by defining AES_ROUND_CTRL_ABORT_EN.
module aes128_encr_round_ctrl #(
  parameter int NR = aes128_pkg::NR_AES128,
  parameter int BLK_W = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BLK_W-1:0]              in_data,
  output logic [aes128_pkg::RK_IDX_W-1:0] rk_idx,
  input  logic [BLK_W-1:0]              rk,
  output logic [BLK_W-1:0]              rnd_state,
  output logic                          rnd_final,
  input  logic [BLK_W-1:0]              rnd_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BLK_W-1:0]              out_data,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic                          abort,
`endif
  output logic                          busy
);
  import aes128_pkg::*;
  localparam int CW = $clog2(NR + 1);
  round_ctrl_state_t st_q;
  logic [CW-1:0] round_q;
  aes_block_t state_q, ark;
  logic last, kill;
`ifdef AES_ROUND_CTRL_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  add_round_key_encr u_ark (.data_i(in_data), .rk_i(rk), .data_o(ark));
  assign last      = round_q == CW'(NR);
  assign in_ready  = st_q == IDLE ? 1'b1 : st_q == DONE ? out_ready : 1'b0;
  assign out_valid = st_q == DONE;
  assign busy      = st_q != IDLE;
  assign rk_idx    = st_q == ROUND ? RK_IDX_W'(round_q) : '0;
  assign rnd_final = st_q == ROUND && last;
  assign rnd_state = state_q;
  assign out_data  = state_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      round_q <= '0;
      state_q <= '0;
    end else if (kill) begin
      // in IDLE abort only blocks acceptance; the last ciphertext is kept
      st_q    <= IDLE;
      round_q <= '0;
      state_q <= st_q == IDLE ? state_q : '0;
    end else begin
      case (st_q)
        IDLE: if (in_valid) begin
          state_q <= ark;
          round_q <= CW'(1);
          st_q    <= ROUND;
        end
        ROUND: begin
          state_q <= rnd_result;
          if (last) st_q <= DONE;
          else round_q <= round_q + 1'b1;
        end
        DONE: if (out_ready) begin
          if (in_valid) begin
            state_q <= ark;
            round_q <= CW'(1);
            st_q    <= ROUND;
          end else begin
            round_q <= '0;
            st_q    <= IDLE;
          end
        end
        default: begin
          st_q    <= IDLE;
          round_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_encr_round_ctrl.sv
// tb_aes128_encr_round_ctrl: scoreboard bench with a reference AES round datapath and key store.
module tb_aes128_encr_round_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] in_data = '0, rk, rnd_state, rnd_result, out_data;
  logic in_ready, rnd_final, out_valid, busy;
  logic [3:0] rk_idx;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif
  int total = 0, passed = 0;
  logic [127:0] exp_q[$];
  logic [127:0] rks [16];
  logic [2047:0] sbox_tbl = 2048'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ARK1 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes128_encr_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk(rk), .rnd_state(rnd_state), .rnd_final(rnd_final),
    .rnd_result(rnd_result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_tbl[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sb(s[127 - 8 * i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r + 4 * c] = a[r + 4 * ((c + r) % 4)];
    if (!fin)
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        a0 = b[4 * c]; a1 = b[4 * c + 1]; a2 = b[4 * c + 2]; a3 = b[4 * c + 3];
        b[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = b[i];
    return o ^ k;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 16; r++) rks[r] = r < 11 ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : '0;
  endtask

  assign rk = rks[rk_idx];
  assign rnd_result = aes_round(rnd_state, rk, rnd_final);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: one pop per completed output transfer
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got %h with no expected block", out_data);
      end else chk("sb_out_data", out_data, exp_q.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    expand(KEY1);
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rk_idx", rk_idx, 0);
    chk("rst_rnd_final", rnd_final, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();
    // FIPS-197 App. B block with rk_idx/rnd_final trace and backpressure
    in_data = PT1; in_valid = 1'b1;
    chk("idle_rk_idx", rk_idx, 0);
    exp_q.push_back(CT1);
    tick();
    in_valid = 1'b0; in_data = 128'hdeadbeef;
    chk("ark_state", rnd_state, ARK1);
    for (int j = 0; j < 10; j++) begin
      chk("trace_rk_idx", rk_idx, j + 1);
      chk("trace_final", rnd_final, j == 9);
      chk("trace_no_valid", out_valid, 0);
      tick();
    end
    chk("latency_valid", out_valid, 1);
    chk("done_rk_idx", rk_idx, 0);
    in_valid = 1'b1; in_data = PT2;
    for (int j = 0; j < 20; j++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_data", out_data, CT1);
      chk("bp_out_valid", out_valid, 1);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_valid", out_valid, 0);
    // back-to-back blocks with zero bubble
    in_data = PT1; in_valid = 1'b1;
    exp_q.push_back(CT1);
    tick();
    for (int j = 0; j < 10; j++) tick();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_in_ready", in_ready, 1);
    exp_q.push_back(CT1);
    tick();
    in_valid = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_ark", rnd_state, ARK1);
    chk("b2b_no_valid", out_valid, 0);
    for (int j = 0; j < 10; j++) tick();
    chk("b2b_valid2", out_valid, 1);
    tick();
    chk("b2b_idle", busy, 0);
    // reset during round 5 discards the block
    in_data = PT1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    chk("pre_rst_rk_idx", rk_idx, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    // FIPS-197 App. C.1 vector after reset
    expand(KEY2);
    in_data = PT2; in_valid = 1'b1;
    exp_q.push_back(CT2);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk("c1_latency", n, 10);
    tick();
`ifdef AES_ROUND_CTRL_ABORT_EN
    in_data = PT2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("pre_abort_rk_idx", rk_idx, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    abort = 1'b1; in_valid = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_idle_busy", busy, 0);
    for (int j = 0; j < 12; j++) tick();
`endif
    tick(); tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
